// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler feeding target/request pulses to the elevator controller
// Latches hall/car calls into a pending bitmap and sequences them one target at a time.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS       = 4,
  parameter int FLOOR_W          = 2,
  parameter int REQ_PULSE_CYCLES = 2,
  parameter int ARRIVE_TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  up_request,
  output logic                  down_request,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  dir_down,
  output logic                  fault,
  output logic [2:0]            sched_state
);

  localparam int SPAN = 1 << FLOOR_W;
  localparam int PW   = $clog2(REQ_PULSE_CYCLES + 1);
  localparam int TW   = $clog2(ARRIVE_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(REQ_PULSE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT    = TW'(ARRIVE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_WAIT     = 3'd2,
    S_SERVICE  = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  up_q, up_d, down_q, down_d;
  logic                  served_q, served_d;
  logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
  logic                  dir_q, dir_d;
  logic                  fault_q, fault_d;
  logic [PW-1:0]         pulse_q, pulse_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [SPAN-1:0]       cur_onehot, call_onehot, tgt_onehot;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic                  above_found, below_found;
  logic [FLOOR_W-1:0]    above_floor, below_floor, sel_floor;
  logic                  sel_dir;

  // SCAN selection: nearest pending floor ahead, else reverse and take the nearest behind.
  always_comb begin
    cur_onehot  = SPAN'(1) << current_floor;
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && FLOOR_W'(i) > current_floor) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && FLOOR_W'(i) < current_floor) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
    sel_floor = current_floor;
    sel_dir   = dir_q;
    if (|(pending_q & cur_onehot[NUM_FLOORS-1:0])) begin
      sel_floor = current_floor;
    end else if (!dir_q) begin
      if (above_found) begin
        sel_floor = above_floor;
      end else begin
        sel_floor = below_floor;
        sel_dir   = 1'b1;
      end
    end else begin
      if (below_found) begin
        sel_floor = below_floor;
      end else begin
        sel_floor = above_floor;
        sel_dir   = 1'b0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    dir_d          = dir_q;
    fault_d        = fault_q;
    up_d           = 1'b0;
    down_d         = 1'b0;
    served_d       = 1'b0;
    served_floor_d = served_floor_q;
    pulse_d        = '0;
    timer_d        = '0;
    clr_mask       = '0;
    call_onehot    = SPAN'(1) << call_floor;
    tgt_onehot     = SPAN'(1) << target_q;
    set_mask       = call_valid ? call_onehot[NUM_FLOORS-1:0] : '0;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          target_d = sel_floor;
          dir_d    = sel_dir;
          state_d  = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (pulse_q == '0) begin
          if (target_q == current_floor) begin
            clr_mask       = tgt_onehot[NUM_FLOORS-1:0];
            served_d       = 1'b1;
            served_floor_d = target_q;
            state_d        = S_SERVICE;
          end else begin
            up_d    = target_q > current_floor;
            down_d  = target_q < current_floor;
            pulse_d = PW'(1);
          end
        end else if (pulse_q != PULSE_LAST) begin
          up_d    = up_q;
          down_d  = down_q;
          pulse_d = pulse_q + PW'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (target_q == current_floor && door_open) begin
          clr_mask       = tgt_onehot[NUM_FLOORS-1:0];
          served_d       = 1'b1;
          served_floor_d = target_q;
          state_d        = S_SERVICE;
        end else if (timer_q == TIMEOUT) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SERVICE: begin
        if (!door_open) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (!emergency_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Emergency overrides everything, including a clear that would otherwise happen this edge.
    if (emergency_stop) begin
      state_d        = S_HOLD;
      target_d       = target_q;
      dir_d          = dir_q;
      fault_d        = fault_q;
      up_d           = 1'b0;
      down_d         = 1'b0;
      served_d       = 1'b0;
      served_floor_d = served_floor_q;
      pulse_d        = '0;
      timer_d        = '0;
      clr_mask       = '0;
    end

    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      target_q       <= '0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      served_q       <= 1'b0;
      served_floor_q <= '0;
      dir_q          <= 1'b0;
      fault_q        <= 1'b0;
      pulse_q        <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_q       <= target_d;
      up_q           <= up_d;
      down_q         <= down_d;
      served_q       <= served_d;
      served_floor_q <= served_floor_d;
      dir_q          <= dir_d;
      fault_q        <= fault_d;
      pulse_q        <= pulse_d;
      timer_q        <= timer_d;
    end
  end

  assign target_floor = target_q;
  assign up_request   = up_q;
  assign down_request = down_q;
  assign pending      = pending_q;
  assign served       = served_q;
  assign served_floor = served_floor_q;
  assign dir_down     = dir_q;
  assign fault        = fault_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - scoreboard bench for elevator_call_scheduler
// Expected served floors are queued as arrivals are driven and compared on each served pulse.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       call_valid = 1'b0;
  logic [1:0] call_floor = '0;
  logic [1:0] current_floor = '0;
  logic       door_open = 1'b0;
  logic       emergency_stop = 1'b0;
  logic [1:0] target_floor;
  logic       up_request;
  logic       down_request;
  logic [3:0] pending;
  logic       served;
  logic [1:0] served_floor;
  logic       dir_down;
  logic       fault;
  logic [2:0] sched_state;

  elevator_call_scheduler #(
    .NUM_FLOORS(4), .FLOOR_W(2), .REQ_PULSE_CYCLES(2), .ARRIVE_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .current_floor(current_floor), .door_open(door_open), .emergency_stop(emergency_stop),
    .target_floor(target_floor), .up_request(up_request), .down_request(down_request),
    .pending(pending), .served(served), .served_floor(served_floor), .dir_down(dir_down),
    .fault(fault), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && served === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_extra_served", 32'(exp_q.size()), 32'd1);
      else chk("served_floor", 32'(served_floor), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input logic [1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick();
    call_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (sched_state !== s && n < 400) begin tick(); n++; end
    chk(tag, 32'(sched_state), 32'(s));
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!(up_request || down_request) && n < 400) begin tick(); n++; end
    chk(tag, 32'(up_request | down_request), 32'd1);
  endtask

  task automatic wait_served(input string tag);
    int n = 0;
    while (served !== 1'b1 && n < 400) begin tick(); n++; end
    chk(tag, 32'(served), 32'd1);
  endtask

  // Bench-side controller: ride to the floor the bench expects next and open the door.
  task automatic visit(input logic [1:0] f, input logic up_exp, input string tag);
    wait_req({tag, "_req"});
    chk({tag, "_dir"}, 32'(up_request), 32'(up_exp));
    exp_q.push_back(32'(f));
    current_floor = f;
    door_open = 1'b1;
    wait_served({tag, "_served"});
    door_open = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int saw_req;
    int saw_served;

    // Reset values and single upward dispatch with exact latency.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_target", 32'(target_floor), 32'd0);
    chk("rst_req", 32'({up_request, down_request}), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_flags", 32'({served, dir_down, fault}), 32'd0);
    chk("rst_state", 32'(sched_state), 32'd0);
    reset = 1'b0;
    current_floor = 2'd2;
    exp_q.push_back(32'd3);
    call(2'd3);
    chk("t1_pend_set", 32'(pending), 32'h8);
    tick();
    chk("t1_dispatch", 32'(sched_state), 32'd1);
    chk("t1_no_req_yet", 32'(up_request), 32'd0);
    tick();
    chk("t1_up_c1", 32'(up_request), 32'd1);
    chk("t1_target", 32'(target_floor), 32'd3);
    chk("t1_down_low", 32'(down_request), 32'd0);
    tick();
    chk("t1_up_c2", 32'(up_request), 32'd1);
    tick();
    chk("t1_up_drop", 32'(up_request), 32'd0);
    chk("t1_wait", 32'(sched_state), 32'd2);
    current_floor = 2'd3;
    door_open = 1'b1;
    tick();
    chk("t1_served", 32'(served), 32'd1);
    chk("t1_pend_clr", 32'(pending), 32'd0);
    door_open = 1'b0;
    tick();
    tick();

    // SCAN order: calls 0,3,2 collected under emergency hold from floor 1, direction up.
    do_reset();
    current_floor = 2'd1;
    emergency_stop = 1'b1;
    call(2'd0);
    call(2'd3);
    call(2'd2);
    chk("t2_pend_all", 32'(pending), 32'hD);
    emergency_stop = 1'b0;
    visit(2'd2, 1'b1, "t2_f2");
    visit(2'd3, 1'b1, "t2_f3");
    visit(2'd0, 1'b0, "t2_f0");
    chk("t2_dir_down", 32'(dir_down), 32'd1);

    // Call for the current floor: no request, served pulse shortly after.
    do_reset();
    current_floor = 2'd2;
    exp_q.push_back(32'd2);
    call(2'd2);
    saw_req = 0;
    saw_served = 0;
    for (int k = 0; k < 3; k++) begin
      if (up_request || down_request) saw_req = 1;
      if (served) saw_served = 1;
      tick();
    end
    chk("t3_no_req", 32'(saw_req), 32'd0);
    chk("t3_served", 32'(saw_served), 32'd1);
    chk("t3_pend", 32'(pending), 32'd0);

    // Emergency stop during the request pulse; calls still latch; release re-dispatches.
    do_reset();
    current_floor = 2'd1;
    call(2'd3);
    wait_req("t4_req");
    emergency_stop = 1'b1;
    tick();
    chk("t4_req_drop", 32'({up_request, down_request}), 32'd0);
    chk("t4_hold", 32'(sched_state), 32'd4);
    call(2'd0);
    call(2'd3);
    chk("t4_pend_kept", 32'(pending), 32'h9);
    emergency_stop = 1'b0;
    visit(2'd3, 1'b1, "t4_f3");
    visit(2'd0, 1'b0, "t4_f0");

    // Arrival timeout: sticky fault, bit retained, back through IDLE and re-dispatched.
    do_reset();
    current_floor = 2'd0;
    call(2'd2);
    wait_req("t5_req");
    begin
      int n = 0;
      while (fault !== 1'b1 && n < 400) begin tick(); n++; end
    end
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_idle", 32'(sched_state), 32'd0);
    chk("t5_pend", 32'(pending), 32'h4);
    visit(2'd2, 1'b1, "t5_redo");
    chk("t5_sticky", 32'(fault), 32'd1);

    // Re-call in the served cycle loses to the clear; then reset mid-wait.
    do_reset();
    current_floor = 2'd0;
    call(2'd1);
    wait_state(3'd2, "t6_wait");
    exp_q.push_back(32'd1);
    current_floor = 2'd1;
    door_open = 1'b1;
    call_valid = 1'b1;
    call_floor = 2'd1;
    tick();
    call_valid = 1'b0;
    chk("t6_served", 32'(served), 32'd1);
    chk("t6_pend_clr", 32'(pending), 32'd0);
    tick();
    chk("t6_pend_stay", 32'(pending), 32'd0);
    door_open = 1'b0;
    tick();
    tick();
    call(2'd3);
    wait_state(3'd2, "t6_wait2");
    reset = 1'b1;
    tick();
    chk("t6_rst_pend", 32'(pending), 32'd0);
    chk("t6_rst_out", 32'({target_floor, up_request, down_request, served, served_floor, dir_down, fault}), 32'd0);
    chk("t6_rst_state", 32'(sched_state), 32'd0);
    reset = 1'b0;
    tick();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
